// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MIPS multiply/divide unit owning the HI/LO pair.
//               Shift-add multiply and restoring divide on magnitudes, with
//               sign correction in a final fix-up cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [2:0]         c_OP_MTHI  = 3'b100;
    localparam logic [2:0]         c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_a, r_b, r_acc_hi, r_acc_lo, r_hi, r_lo;
    logic                 r_neg_q, r_neg_r, r_is_div, r_done, r_dbz;

    logic                 w_accept, w_long_op, w_signed_op, w_rs_neg, w_rt_neg;
    logic [WIDTH-1:0]     w_rs_mag, w_rt_mag, w_div_sub, w_quo, w_rem;
    logic [WIDTH:0]       w_mul_sum, w_div_shift;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_mul_raw, w_prod;

    assign w_accept    = start && (r_state == S_IDLE);
    assign w_long_op   = ~op[2];
    assign w_signed_op = ~op[0];
    assign w_rs_neg    = w_signed_op & rs[WIDTH-1];
    assign w_rt_neg    = w_signed_op & rt[WIDTH-1];
    assign w_rs_mag    = w_rs_neg ? -rs : rs;
    assign w_rt_mag    = w_rt_neg ? -rt : rt;

    // Multiply step: add multiplicand when the current multiplier bit is set, then shift right.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

    // Restoring divide step; the partial remainder stays below 2*divisor, so a WIDTH-bit subtract suffices.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_b};
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

    generate
        if (FAST_MUL) begin : g_fast_mul
            assign w_mul_raw = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
        end else begin : g_iter_mul
            assign w_mul_raw = {r_acc_hi, r_acc_lo};
        end
    endgenerate

    assign w_prod = r_neg_q ? -w_mul_raw : w_mul_raw;
    assign w_quo  = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem  = r_neg_r ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_long_op)
                    w_state_nxt = (FAST_MUL && !op[1]) ? S_FIX : S_RUN;
            end
            S_RUN:   if (r_cnt == c_CNT_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept && w_long_op) begin
                        r_a      <= w_rs_mag;
                        r_b      <= w_rt_mag;
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_is_div <= op[1];
                        r_cnt    <= '0;
                        r_acc_hi <= '0;
                        r_acc_lo <= op[1] ? w_rs_mag : w_rt_mag;
                    end else if (w_accept && op == c_OP_MTHI) begin
                        r_hi <= rs;
                    end else if (w_accept && op == c_OP_MTLO) begin
                        r_lo <= rs;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc_hi <= w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (r_b == '0) begin
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Table-driven bench for muldiv_unit, iterative and fast-multiply
//               instances, plus hand-written multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk, rst, start, start_f;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, done, dbz, busy_f, done_f, dbz_f;
    logic [31:0] hi, lo, hi_f, lo_f;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        string       name;
    } vec_t;

    vec_t vecs[14];

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .start(start_f), .op(op), .rs(rs), .rt(rt),
        .busy(busy_f), .done(done_f), .div_by_zero(dbz_f), .hi(hi_f), .lo(lo_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a request for one edge, then scrambles operands to prove they were latched.
    task automatic issue(input bit fast, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs = a; rt = b;
        if (fast) start_f = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_f = 1'b0;
        rs = ~a; rt = ~b;
    endtask

    // Waits for done with a bound; optionally injects a MULT request while busy.
    task automatic wait_done(input bit fast, input int inject_at, output int lat, output bit held);
        held = 1'b1;
        lat  = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == inject_at) begin
                op = 3'b000; rs = 32'hFFFF_FFFF; rt = 32'd7;
                if (fast) start_f = 1'b1; else start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0; start_f = 1'b0;
            if (fast ? done_f : done) begin
                lat = c;
                break;
            end
            if (!(fast ? busy_f : busy)) held = 1'b0;
        end
    endtask

    task automatic run_vec(input bit fast, input vec_t v, input int exp_lat, input bit check_tail);
        int lat;
        bit held;
        issue(fast, v.op, v.rs, v.rt);
        wait_done(fast, 0, lat, held);
        chk({v.name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({v.name, "_busy_held"}, 64'(held), 64'd1);
        chk({v.name, "_busy_at_done"}, 64'(fast ? busy_f : busy), 64'd0);
        chk({v.name, "_hi"}, 64'(fast ? hi_f : hi), 64'(v.exp_hi));
        chk({v.name, "_lo"}, 64'(fast ? lo_f : lo), 64'(v.exp_lo));
        chk({v.name, "_dz"}, 64'(fast ? dbz_f : dbz), 64'(v.exp_dz));
        if (check_tail) begin
            @(posedge clk); #1;
            chk({v.name, "_done_pulse"}, 64'({done, dbz, done_f, dbz_f}), 64'd0);
        end
    endtask

    task automatic no_done(input int n, input string name);
        bit seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done || dbz) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  held;
        vec_t v;

        rst = 1'b1; start = 1'b0; start_f = 1'b0; op = 3'b000; rs = '0; rt = '0;

        vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, "mult_m1x7"};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'd7,        32'h0000_0006, 32'hFFFF_FFF9, 1'b0, "multu_max_x7"};
        vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2"};
        vecs[3]  = '{3'b011, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 1'b0, "divu_7_2"};
        vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_min_m1"};
        vecs[5]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_min_min"};
        vecs[6]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max_max"};
        vecs[7]  = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7_m2"};
        vecs[8]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu_max_16"};
        vecs[9]  = '{3'b011, 32'h1234_5678, 32'd0,        32'h0000_000F, 32'h0FFF_FFFF, 1'b1, "divu_by_zero"};
        vecs[10] = '{3'b010, 32'hFFFF_FFF8, 32'd0,        32'h0000_000F, 32'h0FFF_FFFF, 1'b1, "div_by_zero"};
        vecs[11] = '{3'b000, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult_3_m5"};
        vecs[12] = '{3'b010, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 1'b0, "div_100_7"};
        vecs[13] = '{3'b010, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, "div_m100_m7"};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy, done, dbz, hi, lo}), 64'd0);
        chk("reset_state_fast", 64'({busy_f, done_f, dbz_f, hi_f, lo_f}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(1'b0, vecs[i], 33, 1'b1);

        // Fast multiplier: MULT/MULTU finish at the first edge, divide keeps full latency.
        run_vec(1'b1, vecs[1], 1, 1'b1);
        run_vec(1'b1, vecs[0], 1, 1'b1);
        run_vec(1'b1, vecs[3], 33, 1'b1);

        // Start while busy is dropped; the first result must survive untouched.
        issue(1'b0, 3'b001, 32'd7, 32'd2);
        wait_done(1'b0, 5, lat, held);
        chk("busy_start_latency", 64'(lat), 64'd33);
        chk("busy_start_result", 64'({hi, lo}), {32'd0, 32'd14});
        no_done(40, "busy_start_no_second_done");
        chk("busy_start_idle", 64'(busy), 64'd0);

        // A new request accepted in the done cycle.
        issue(1'b0, 3'b011, 32'd7, 32'd2);
        wait_done(1'b0, 0, lat, held);
        chk("b2b_first", 64'({hi, lo}), {32'd1, 32'd3});
        v = '{3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "b2b_second"};
        run_vec(1'b0, v, 33, 1'b1);

        // Reset asserted on the 10th cycle of an operation aborts it.
        issue(1'b0, 3'b000, 32'hFFFF_FFFF, 32'd7);
        repeat (9) @(posedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_state", 64'({busy, done, dbz, hi, lo}), 64'd0);
        rst = 1'b0;
        no_done(40, "rst_mid_no_done");

        // MTHI / MTLO take effect at the accepting edge with no handshake.
        issue(1'b0, 3'b100, 32'h0000_1234, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_flags", 64'({busy, done}), 64'd0);
        issue(1'b0, 3'b101, 32'h0000_5678, 32'd0);
        chk("mtlo_pair", 64'({hi, lo}), {32'h1234, 32'h5678});
        chk("mtlo_flags", 64'({busy, done}), 64'd0);

        // Undefined op is ignored.
        issue(1'b0, 3'b110, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        chk("undef_state", 64'({busy, hi, lo}), {31'd0, 1'b0, 32'h1234, 32'h5678});
        no_done(40, "undef_no_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
